// File: rtl/au_cmp_minmax_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : au_cmp_minmax_seq_pkg
// Purpose : Shared types and constants for the min/max compare sequencer.
//           Contains the 2-bit FSM state encoding and the bit positions
//           inside the result flag vector m_flags.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package au_cmp_minmax_seq_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_CMP_MAX = 2'd1,
        ST_CMP_MIN = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    // Bit positions inside m_flags = {cmp_err, cnt_sat, all_equal}
    localparam int FLG_EQ  = 0;
    localparam int FLG_SAT = 1;
    localparam int FLG_ERR = 2;

endpackage : au_cmp_minmax_seq_pkg
`default_nettype wire

// File: rtl/au_cmp_minmax_seq.sv
`default_nettype none
// ============================================================================
// Module  : au_cmp_minmax_seq
// Purpose : Collects a burst of signed samples and tracks its maximum and
//           minimum by time-sharing one external signed comparator: each
//           sample after the first is compared against the running max and
//           then against the running min. The burst result is offered on a
//           valid/ready port once the final sample has been processed.
// Ports   : clk, rst_n                  clock, async active-low reset
//           s_valid/s_ready/s_data/s_last  sample input stream
//           cmp_a/cmp_b                  operands to the external comparator
//           cmp_e/cmp_g/cmp_l            comparator results (A==B, A>B, A<B)
//           m_valid/m_ready              result handshake
//           m_max/m_min/m_count/m_flags  burst result
// Revision: 1.0 - initial release
// ============================================================================
module au_cmp_minmax_seq
    import au_cmp_minmax_seq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    input  logic             s_last,
    output logic [DW-1:0]    cmp_a,
    output logic [DW-1:0]    cmp_b,
    input  logic             cmp_e,
    input  logic             cmp_g,
    input  logic             cmp_l,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_max,
    output logic [DW-1:0]    m_min,
    output logic [CNT_W-1:0] m_count,
    output logic [2:0]       m_flags
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_first;
    logic             r_last;
    logic [DW-1:0]    r_max;
    logic [DW-1:0]    r_min;
    logic [DW-1:0]    r_sample;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_flags;

    logic             w_hs;
    logic             w_onehot;
    logic             w_in_cmp;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_hs      = s_valid & s_ready;
    assign w_in_cmp  = (r_state == ST_CMP_MAX) || (r_state == ST_CMP_MIN);
    // Exactly one of three bits set: odd parity and not all three.
    assign w_onehot  = (cmp_e ^ cmp_g ^ cmp_l) & ~(cmp_e & cmp_g & cmp_l);
    assign w_cnt_inc = (r_count == C_CNT_MAX) ? r_count : r_count + C_CNT_ONE;

    assign m_max   = r_max;
    assign m_min   = r_min;
    assign m_count = r_count;
    assign m_flags = r_flags;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        cmp_a        = '0;
        cmp_b        = '0;
        case (r_state)
            ST_ACCEPT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (r_first) begin
                        w_next_state = s_last ? ST_RESULT : ST_ACCEPT;
                    end else begin
                        w_next_state = ST_CMP_MAX;
                    end
                end
            end
            ST_CMP_MAX: begin
                cmp_a        = r_sample;
                cmp_b        = r_max;
                w_next_state = ST_CMP_MIN;
            end
            ST_CMP_MIN: begin
                cmp_a        = r_sample;
                cmp_b        = r_min;
                w_next_state = r_last ? ST_RESULT : ST_ACCEPT;
            end
            ST_RESULT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_next_state = ST_ACCEPT;
                end
            end
            default: begin
                w_next_state = ST_ACCEPT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: running max/min, sample buffer, counter and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first  <= 1'b1;
            r_last   <= 1'b0;
            r_max    <= '0;
            r_min    <= '0;
            r_sample <= '0;
            r_count  <= '0;
            r_flags  <= '0;
        end else begin
            if ((r_state == ST_ACCEPT) && w_hs) begin
                if (r_first) begin
                    // First sample seeds both extremes and restarts the burst
                    r_max            <= s_data;
                    r_min            <= s_data;
                    r_first          <= 1'b0;
                    r_count          <= C_CNT_ONE;
                    r_flags[FLG_EQ]  <= 1'b1;
                    r_flags[FLG_ERR] <= 1'b0;
                    r_flags[FLG_SAT] <= (C_CNT_ONE == C_CNT_MAX);
                end else begin
                    r_sample <= s_data;
                    r_last   <= s_last;
                    r_count  <= w_cnt_inc;
                    if (w_cnt_inc == C_CNT_MAX) begin
                        r_flags[FLG_SAT] <= 1'b1;
                    end
                end
            end

            // Inconsistent comparator answers are recorded but do not
            // override the max/min update, which follows G / L only.
            if (w_in_cmp && !w_onehot) begin
                r_flags[FLG_ERR] <= 1'b1;
            end

            if (r_state == ST_CMP_MAX) begin
                if (cmp_g) begin
                    r_max <= r_sample;
                end
                if (!cmp_e) begin
                    r_flags[FLG_EQ] <= 1'b0;
                end
            end

            if ((r_state == ST_CMP_MIN) && cmp_l) begin
                r_min <= r_sample;
            end

            if ((r_state == ST_RESULT) && m_ready) begin
                r_first <= 1'b1;
            end
        end
    end

endmodule : au_cmp_minmax_seq
`default_nettype wire
